// File: rtl/mult_pkg.sv
// Shared definitions for the radix-8 Booth multiplier front end.
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STEPS_S   = 11;
    localparam int STEPS_U   = 12;
    localparam int WIN_SHIFT = 3;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/booth_window_reg.sv
// Multiplier scan register: holds {ext x4, Multiplier, 0} and slides a 4-bit
// overlapping radix-8 Booth window across it, three bits per step.
module booth_window_reg
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Shift,
    input  logic             Sign,
    input  logic [WIDTH-1:0] Multiplier,
    output logic [3:0]       Num
);

    localparam int MW = WIDTH + 5;

    logic signed [MW-1:0] m;
    logic                 ext;

    assign ext = Sign & Multiplier[WIDTH-1];

    // The top bit always carries ext, so an arithmetic shift refills with it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            m <= '0;
        end else if (Load) begin
            m <= {{4{ext}}, Multiplier, 1'b0};
        end else if (Shift) begin
            m <= m >>> WIN_SHIFT;
        end
    end

    assign Num = m[3:0];

endmodule

// File: rtl/mult_booth_sequencer.sv
// Sequencer feeding the Booth partial-product stage: walks the multiplier
// window, recirculates the shifted multiplicand and flags step boundaries.
module mult_booth_sequencer #(
    parameter int WIDTH   = 32,
    parameter int STEPS_S = mult_pkg::STEPS_S,
    parameter int STEPS_U = mult_pkg::STEPS_U
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Sign,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic               Hold,
    input  logic [2*WIDTH-1:0] AfterA,
    output logic [2*WIDTH-1:0] A,
    output logic [3:0]         Num,
    output logic               SignOut,
    output logic               En,
    output logic               StepValid,
    output logic               StepFirst,
    output logic               StepLast,
    output logic               Busy,
    output logic               Done
);

    import mult_pkg::*;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, lastCnt;
    logic             load, consume;

    assign lastCnt = SignOut ? CNT_W'(STEPS_S - 1) : CNT_W'(STEPS_U - 1);

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        consume   = 1'b0;
        StepValid = 1'b0;
        StepFirst = 1'b0;
        StepLast  = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                StepValid = 1'b1;
                Busy      = 1'b1;
                StepFirst = (cnt == '0);
                StepLast  = (cnt == lastCnt);
                consume   = !Hold;
                if (consume && StepLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign En = StepValid;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            A       <= '0;
            cnt     <= '0;
            SignOut <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state <= stateNext;
            Done  <= consume && StepLast;
            if (load) begin
                A       <= Sign ? {{WIDTH{Multiplicand[WIDTH-1]}}, Multiplicand}
                                : {{WIDTH{1'b0}}, Multiplicand};
                cnt     <= '0;
                SignOut <= Sign;
            end else if (consume) begin
                A   <= AfterA;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    booth_window_reg #(
        .WIDTH(WIDTH)
    ) uWindow (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (load),
        .Shift     (consume),
        .Sign      (Sign),
        .Multiplier(Multiplier),
        .Num       (Num)
    );

endmodule
